// File: rtl/bp_pkg.sv
// Shared types for the fetch-stage branch predictor: control-kind encodings, direction counter states, entry metadata.
// Latency: n/a (types and a pure helper function only).
// Backpressure: n/a.
package bp_pkg;

  typedef enum logic [1:0] {
    KIND_NONE = 2'b00,
    KIND_BR   = 2'b01,
    KIND_JAL  = 2'b10,
    KIND_JALR = 2'b11
  } kind_e;

  localparam logic [1:0] CNT_SNT = 2'b00;
  localparam logic [1:0] CNT_WNT = 2'b01;
  localparam logic [1:0] CNT_WT  = 2'b10;
  localparam logic [1:0] CNT_ST  = 2'b11;

  // Width-independent part of a BTB entry; tag/target widths depend on the
  // predictor parameters and are added by the top-level entry struct.
  typedef struct packed {
    kind_e      kind;
    logic       ret;
    logic [1:0] cnt;
  } entry_meta_t;

  // Saturating 2-bit direction counter step.
  function automatic logic [1:0] cnt_next(input logic [1:0] cnt, input logic taken);
    if (taken) return (cnt == CNT_ST) ? CNT_ST : cnt + 2'd1;
    return (cnt == CNT_SNT) ? CNT_SNT : cnt - 2'd1;
  endfunction

endpackage

// File: rtl/bp_ras.sv
// Circular return-address stack fed by resolved calls/returns; top-of-stack and empty flag for fetch.
// Latency: push/pop take effect at the next clock edge; top/empty are read combinationally from registers.
// Backpressure: none; a push when full silently overwrites the oldest entry, a pop when empty is ignored.
module bp_ras #(
  parameter int RAS_D = 8,
  parameter int PC_W  = 13
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            push,
  input  logic            pop,
  input  logic [PC_W-1:0] push_pc,
  output logic [PC_W-1:0] top,
  output logic            empty
);

  localparam int PTR_W = $clog2(RAS_D);
  localparam logic [PTR_W:0] CNT_FULL = (PTR_W + 1)'(RAS_D);

  logic [PC_W-1:0]  stack [RAS_D];
  logic [PTR_W-1:0] ptr;
  logic [PTR_W-1:0] ptr_inc;
  logic [PTR_W:0]   count;
  logic             replace;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign ptr_inc = ptr + 1'b1;
  // Call+return together swaps the top; on an empty stack it degrades to a push.
  assign replace = push & pop & ~empty;
  assign do_push = push & ~replace;
  assign do_pop  = pop & ~push & ~empty;
  assign top     = stack[ptr];

  // Pointer and occupancy; flush empties the stack ahead of any same-cycle op.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr   <= '0;
      count <= '0;
    end else if (flush) begin
      ptr   <= '0;
      count <= '0;
    end else if (do_push) begin
      ptr <= ptr_inc;
      if (count != CNT_FULL) count <= count + 1'b1;
    end else if (do_pop) begin
      ptr   <= ptr - 1'b1;
      count <= count - 1'b1;
    end
  end

  // Return-address storage; contents beyond count are don't-care so no reset.
  always_ff @(posedge clk) begin
    if (!flush) begin
      if (do_push) stack[ptr_inc] <= push_pc;
      else if (replace) stack[ptr] <= push_pc;
    end
  end

endmodule

// File: rtl/branch_predictor.sv
// Fetch-stage predictor: direct-mapped BTB with 2-bit direction counters plus a return-address stack.
// Latency: lookup is zero-cycle from registered state; execute-stage updates are visible the cycle after.
// Backpressure: none; one lookup and one update accepted every cycle, flush drops a same-cycle update.
module branch_predictor
  import bp_pkg::*;
#(
  parameter int PC_W  = 13,
  parameter int IDX_W = 11,
  parameter int RAS_D = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            f_valid,
  input  logic [PC_W-1:0] f_pc,
  output logic [PC_W-1:0] pred_pc,
  output logic            pred_taken,
  output logic            pred_hit,
  input  logic            u_valid,
  input  logic [PC_W-1:0] u_pc,
  input  logic [1:0]      u_kind,
  input  logic            u_taken,
  input  logic [PC_W-1:0] u_target,
  input  logic            u_call,
  input  logic            u_ret
);

  localparam int TAG_W = PC_W - IDX_W;
  localparam int DEPTH = 1 << IDX_W;

  typedef struct packed {
    logic [TAG_W-1:0] tag;
    logic [PC_W-1:0]  target;
    entry_meta_t      meta;
  } entry_t;

  logic [DEPTH-1:0] valid;
  entry_t           btb [DEPTH];

  logic [IDX_W-1:0] f_idx;
  logic [PC_W-1:0]  f_seq;
  logic             f_hit;
  logic [IDX_W-1:0] u_idx;
  logic [TAG_W-1:0] u_tag;
  logic             u_hit;
  logic             u_jump;
  logic             u_en;
  logic             u_alloc;
  entry_t           u_new;
  logic             ras_push;
  logic             ras_pop;
  logic [PC_W-1:0]  ras_top;
  logic             ras_empty;

  assign f_idx = f_pc[IDX_W-1:0];
  assign f_seq = f_pc + PC_W'(1);
  assign f_hit = f_valid & valid[f_idx] & (btb[f_idx].tag == f_pc[PC_W-1:IDX_W]);

  // Lookup: returns prefer the RAS, jumps always redirect, branches follow the counter MSB.
  always_comb begin
    pred_hit   = f_hit;
    pred_taken = 1'b0;
    pred_pc    = f_seq;
    if (f_hit) begin
      if (btb[f_idx].meta.ret) begin
        pred_taken = 1'b1;
        pred_pc    = ras_empty ? btb[f_idx].target : ras_top;
      end else if (btb[f_idx].meta.kind == KIND_JAL || btb[f_idx].meta.kind == KIND_JALR) begin
        pred_taken = 1'b1;
        pred_pc    = btb[f_idx].target;
      end else if (btb[f_idx].meta.kind == KIND_BR && btb[f_idx].meta.cnt[1]) begin
        pred_taken = 1'b1;
        pred_pc    = btb[f_idx].target;
      end
    end
  end

  assign u_idx   = u_pc[IDX_W-1:0];
  assign u_tag   = u_pc[PC_W-1:IDX_W];
  assign u_hit   = valid[u_idx] & (btb[u_idx].tag == u_tag);
  assign u_jump  = (u_kind == KIND_JAL) | (u_kind == KIND_JALR);
  assign u_en    = u_valid & (u_kind != KIND_NONE) & ~flush;
  // A not-taken branch that misses is not worth a BTB slot.
  assign u_alloc = u_en & (u_hit | u_taken | u_jump);

  // Build the entry written on update; a return flag only means something on jalr.
  always_comb begin
    u_new.tag       = u_tag;
    u_new.target    = u_target;
    u_new.meta.kind = kind_e'(u_kind);
    u_new.meta.ret  = u_ret & (u_kind == KIND_JALR);
    if (u_jump) u_new.meta.cnt = CNT_ST;
    else if (u_hit) u_new.meta.cnt = cnt_next(btb[u_idx].meta.cnt, u_taken);
    else u_new.meta.cnt = CNT_WT;
  end

  // Valid bits carry the reset/flush semantics so the payload array needs no reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) valid <= '0;
    else if (flush) valid <= '0;
    else if (u_alloc) valid[u_idx] <= 1'b1;
  end

  // BTB payload write on allocate/refresh.
  always_ff @(posedge clk) begin
    if (u_alloc) btb[u_idx] <= u_new;
  end

  assign ras_push = u_valid & u_call & u_jump & ~flush;
  assign ras_pop  = u_valid & u_ret & (u_kind == KIND_JALR) & ~flush;

  bp_ras #(
    .RAS_D(RAS_D),
    .PC_W (PC_W)
  ) u_ras (
    .clk    (clk),
    .rst    (rst),
    .flush  (flush),
    .push   (ras_push),
    .pop    (ras_pop),
    .push_pc(u_pc + PC_W'(1)),
    .top    (ras_top),
    .empty  (ras_empty)
  );

endmodule

// File: tb/tb_branch_predictor.sv
// Self-checking bench for branch_predictor: directed scenarios plus randomized traffic vs a behavioural model.
// Latency: lookups compared combinationally mid-cycle; updates applied to the model at each rising edge.
// Backpressure: n/a.
module tb_branch_predictor;

  localparam int PC_W  = 13;
  localparam int IDX_W = 11;
  localparam int RAS_D = 8;
  localparam int NIDX  = 1 << IDX_W;
  localparam int NPC   = 1 << PC_W;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            flush = 1'b0;
  logic            f_valid = 1'b0;
  logic [PC_W-1:0] f_pc = '0;
  logic [PC_W-1:0] pred_pc;
  logic            pred_taken;
  logic            pred_hit;
  logic            u_valid = 1'b0;
  logic [PC_W-1:0] u_pc = '0;
  logic [1:0]      u_kind = 2'b00;
  logic            u_taken = 1'b0;
  logic [PC_W-1:0] u_target = '0;
  logic            u_call = 1'b0;
  logic            u_ret = 1'b0;

  int checks = 0;
  int errors = 0;

  // Reference model: per-index entry arrays and the RAS as a bounded queue.
  bit m_v   [NIDX];
  int m_tag [NIDX];
  int m_tgt [NIDX];
  int m_kind[NIDX];
  bit m_ret [NIDX];
  int m_cnt [NIDX];
  int ras[$];

  branch_predictor #(.PC_W(PC_W), .IDX_W(IDX_W), .RAS_D(RAS_D)) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .f_valid   (f_valid),
    .f_pc      (f_pc),
    .pred_pc   (pred_pc),
    .pred_taken(pred_taken),
    .pred_hit  (pred_hit),
    .u_valid   (u_valid),
    .u_pc      (u_pc),
    .u_kind    (u_kind),
    .u_taken   (u_taken),
    .u_target  (u_target),
    .u_call    (u_call),
    .u_ret     (u_ret)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NIDX; i++) m_v[i] = 1'b0;
    ras.delete();
  endtask

  task automatic model_predict(input bit fv, input int pc, output int hit, output int tk, output int npc);
    int idx;
    idx = pc % NIDX;
    hit = 0; tk = 0; npc = (pc + 1) % NPC;
    if (fv && m_v[idx] && m_tag[idx] == pc / NIDX) begin
      hit = 1;
      if (m_ret[idx]) begin
        tk = 1;
        npc = (ras.size() > 0) ? ras[$] : m_tgt[idx];
      end else if (m_kind[idx] >= 2 || m_cnt[idx] >= 2) begin
        tk = 1;
        npc = m_tgt[idx];
      end
    end
  endtask

  task automatic model_update();
    int idx, k, pc, ncnt;
    bit hit, jump, push, pop;
    if (flush) begin
      model_reset();
      return;
    end
    if (!u_valid || u_kind == 2'b00) return;
    k = int'(u_kind);
    pc = int'(u_pc);
    idx = pc % NIDX;
    jump = (k >= 2);
    hit = m_v[idx] && (m_tag[idx] == pc / NIDX);
    if (hit || u_taken || jump) begin
      if (jump) ncnt = 3;
      else if (!hit) ncnt = 2;
      else if (u_taken) ncnt = (m_cnt[idx] < 3) ? m_cnt[idx] + 1 : 3;
      else ncnt = (m_cnt[idx] > 0) ? m_cnt[idx] - 1 : 0;
      m_v[idx] = 1'b1;
      m_tag[idx] = pc / NIDX;
      m_tgt[idx] = int'(u_target);
      m_kind[idx] = k;
      m_ret[idx] = u_ret && (k == 3);
      m_cnt[idx] = ncnt;
    end
    push = u_call && jump;
    pop = u_ret && (k == 3);
    if (push && pop && ras.size() > 0) ras[ras.size() - 1] = (pc + 1) % NPC;
    else if (push) begin
      ras.push_back((pc + 1) % NPC);
      if (ras.size() > RAS_D) void'(ras.pop_front());
    end else if (pop && ras.size() > 0) void'(ras.pop_back());
  endtask

  // One cycle: compare the lookup against the model, clock the update in, clear update inputs.
  task automatic tick();
    int eh, et, ep;
    #1;
    model_predict(f_valid, int'(f_pc), eh, et, ep);
    check("lk_hit", pred_hit, eh);
    check("lk_taken", pred_taken, et);
    check("lk_pc", pred_pc, ep);
    @(posedge clk);
    model_update();
    @(negedge clk);
    u_valid = 1'b0; u_kind = 2'b00; u_call = 1'b0; u_ret = 1'b0; flush = 1'b0;
  endtask

  task automatic upd(input int pc, input int kind, input bit tk, input int tgt,
                     input bit call = 1'b0, input bit ret = 1'b0);
    u_valid = 1'b1; u_pc = PC_W'(pc); u_kind = 2'(kind); u_taken = tk;
    u_target = PC_W'(tgt); u_call = call; u_ret = ret;
  endtask

  task automatic probe(input string tag, input int pc, input int exp_pc);
    f_valid = 1'b1;
    f_pc = PC_W'(pc);
    #1;
    check(tag, pred_pc, exp_pc);
    tick();
  endtask

  initial begin
    model_reset();
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Out of reset
    f_valid = 1'b1; f_pc = 13'h0040;
    #1;
    check("rst_hit", pred_hit, 0);
    check("rst_taken", pred_taken, 0);
    tick();
    probe("rst_pc", 'h040, 'h041);

    // Conditional branch counter walk
    upd('h100, 1, 1, 'h180); tick();
    probe("br_alloc", 'h100, 'h180);
    upd('h100, 1, 0, 'h180); tick();
    probe("br_wnt", 'h100, 'h101);
    upd('h100, 1, 0, 'h180); tick();
    probe("br_snt", 'h100, 'h101);
    repeat (4) begin upd('h100, 1, 1, 'h180); tick(); end
    probe("br_st", 'h100, 'h180);
    upd('h100, 1, 0, 'h180); tick();
    probe("br_sat", 'h100, 'h180);
    upd('h100, 1, 0, 'h180); tick();
    probe("br_down", 'h100, 'h101);
    upd('h123, 1, 0, 'h190); tick();
    probe("br_nt_noalloc", 'h123, 'h124);

    // Aliasing on one index
    upd('h005, 2, 1, 'h050); tick();
    upd('h805, 2, 1, 'h0A0); tick();
    probe("alias_old", 'h005, 'h006);
    probe("alias_new", 'h805, 'h0A0);

    // Return-address stack
    upd('h200, 3, 1, 'h111, 1'b0, 1'b1); tick();
    probe("ret_empty", 'h200, 'h111);
    upd('h010, 2, 1, 'h400, 1'b1); tick();
    upd('h020, 2, 1, 'h400, 1'b1); tick();
    upd('h030, 2, 1, 'h400, 1'b1); tick();
    probe("ras_top", 'h200, 'h031);
    upd('h200, 3, 1, 'h111, 1'b0, 1'b1); tick();
    probe("ras_pop", 'h200, 'h021);
    for (int i = 0; i < 9; i++) begin upd('h040 + 16 * i, 2, 1, 'h400, 1'b1); tick(); end
    for (int i = 0; i < 8; i++) begin
      upd('h200, 3, 1, 'h111, 1'b0, 1'b1);
      probe("ras_lifo", 'h200, 'h041 + 16 * (8 - i));
    end
    upd('h200, 3, 1, 'h111, 1'b0, 1'b1);
    probe("ras_drained", 'h200, 'h111);
    probe("ras_still_empty", 'h200, 'h111);

    // Same-cycle lookup and update
    upd('h300, 2, 1, 'h333);
    probe("same_old", 'h300, 'h301);
    probe("same_new", 'h300, 'h333);

    // Flush beats a concurrent update
    upd('h700, 2, 1, 'h777, 1'b1); flush = 1'b1; tick();
    probe("fl_upd", 'h700, 'h701);
    probe("fl_old", 'h300, 'h301);
    probe("fl_ret", 'h200, 'h201);

    // Asynchronous reset with populated state
    upd('h200, 3, 1, 'h111, 1'b0, 1'b1); tick();
    for (int i = 0; i < 10; i++) begin upd('h050 + i, 2, 1, 'h600 + i, 1'b1); tick(); end
    probe("pre_arst", 'h200, 'h05A);
    f_valid = 1'b1; f_pc = 13'h0200;
    #2 rst = 1'b1;
    #1;
    check("arst_hit", pred_hit, 0);
    check("arst_taken", pred_taken, 0);
    check("arst_pc", pred_pc, 'h201);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    probe("arst_ret", 'h200, 'h201);

    // Randomized traffic over a small PC pool so entries collide and get reused
    for (int n = 0; n < 800; n++) begin
      int k;
      f_valid = ($urandom_range(0, 9) != 0);
      f_pc = PC_W'($urandom_range(0, 3) * NIDX + $urandom_range(0, 7));
      if ($urandom_range(0, 2) != 0) begin
        k = $urandom_range(0, 3);
        upd($urandom_range(0, 3) * NIDX + $urandom_range(0, 7), k,
            (k >= 2) ? 1'b1 : 1'($urandom_range(0, 1)), $urandom_range(0, NPC - 1),
            ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0));
      end
      flush = ($urandom_range(0, 59) == 0);
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
